// File: rtl/alu_pkg.sv
// Shared ALU package: operation encoding, datapath width and the
// command record buffered in front of the ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_SLTU = 3'd7
  } operand_t;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    operand_t             op;
  } alu_cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational WIDTH-bit ALU; carries out of the top bit are dropped.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  operand_t         op_i,
  output logic [WIDTH-1:0] y_o
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] sh;
  assign sh = b_i[SW-1:0];

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SLL:  y_o = a_i << sh;
      OP_SRL:  y_o = a_i >> sh;
      OP_SLTU: y_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
    endcase
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO; occupancy comes from an explicit counter, so
// full/empty never depend on comparing the wrapping pointers.
module sync_fifo #(
  parameter  int EW    = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [EW-1:0] wdata_i,
  output logic [EW-1:0] rdata_o,
  output logic [CW-1:0] count_o
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PW'(1);
      if (pop_i)  rptr_d = rptr_q + PW'(1);
      if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of the ALU with a registered valid/ready
// result stage; back-pressure on both the command and result side.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = ALU_WIDTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  input  operand_t         cmd_op_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_o,
  output operand_t         res_op_o,
  output logic [CW-1:0]    count_o
);

  localparam int EW = $bits(alu_cmd_t);

  alu_cmd_t         wcmd, head;
  logic [EW-1:0]    head_raw;
  logic [CW-1:0]    count;
  logic             push, pop;
  logic [WIDTH-1:0] alu_y;

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  operand_t         res_op_q, res_op_d;

  assign wcmd        = '{a: cmd_a_i, b: cmd_b_i, op: cmd_op_i};
  assign head        = alu_cmd_t'(head_raw);
  assign cmd_ready_o = (count != CW'(DEPTH)) && !flush_i;
  assign push        = cmd_valid_i && cmd_ready_o;
  // Issue only when the result slot is free or being drained this cycle
  assign pop = (count != '0) && (!res_valid_q || res_ready_i) && !flush_i;

  sync_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wcmd),
    .rdata_o (head_raw),
    .count_o (count)
  );

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a_i  (head.a),
    .b_i  (head.b),
    .op_i (head.op),
    .y_o  (alu_y)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_d       = res_q;
    res_op_d    = res_op_q;
    if (flush_i) begin
      res_valid_d = 1'b0;
    end else if (pop) begin
      res_valid_d = 1'b1;
      res_d       = alu_y;
      res_op_d    = head.op;
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_op_q    <= OP_ADD;
    end else begin
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_op_q    <= res_op_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;
  assign res_op_o    = res_op_q;
  assign count_o     = count;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: constant vector table, directed
// corner sequences and a random stream against a scoreboard model.
module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          flush_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [7:0]    cmd_a_i;
  logic [7:0]    cmd_b_i;
  operand_t      cmd_op_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [7:0]    res_o;
  operand_t      res_op_o;
  logic [CW-1:0] count_o;

  alu_cmd_queue #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_a_i     (cmd_a_i),
    .cmd_b_i     (cmd_b_i),
    .cmd_op_i    (cmd_op_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_o       (res_o),
    .res_op_o    (res_op_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    operand_t   op;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    operand_t   op;
    logic [7:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  int   m_cnt;
  bit   m_rv;
  int   errs;
  int   checks;
  vec_t vecs[12];

  function automatic logic [7:0] ref_alu(int a, int b, operand_t op);
    int r;
    case (op)
      OP_ADD:  r = (a + b) % 256;
      OP_SUB:  r = (a - b + 256) % 256;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = (a * (1 << (b % 8))) % 256;
      OP_SRL:  r = a / (1 << (b % 8));
      default: r = (a < b) ? 1 : 0;
    endcase
    return r[7:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cmd(logic v, logic [7:0] a, logic [7:0] b, operand_t op);
    cmd_valid_i = v;
    cmd_a_i     = a;
    cmd_b_i     = b;
    cmd_op_i    = op;
    cur_exp.res = ref_alu(int'(a), int'(b), op);
    cur_exp.op  = op;
  endtask

  // One clock: observe handshakes, advance the model, then check state.
  task automatic tick();
    bit acc;
    bit iss;
    #1;
    chk("cmd_ready", cmd_ready_o, (m_cnt != DEPTH) && !flush_i);
    acc = cmd_valid_i && (m_cnt != DEPTH) && !flush_i;
    iss = (m_cnt != 0) && (!m_rv || res_ready_i) && !flush_i;
    if (m_rv && res_ready_i && !flush_i) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("res", res_o, sb[0].res);
        chk("res_op", res_op_o, sb[0].op);
        void'(sb.pop_front());
      end
    end
    if (flush_i) begin
      m_cnt = 0;
      m_rv  = 0;
      sb.delete();
    end else begin
      m_cnt = m_cnt + int'(acc) - int'(iss);
      if (iss) m_rv = 1;
      else if (res_ready_i) m_rv = 0;
      if (acc) sb.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
    chk("count", count_o, m_cnt);
    chk("res_valid", res_valid_o, m_rv);
  endtask

  task automatic drain();
    cmd_valid_i = 0;
    flush_i     = 0;
    res_ready_i = 1;
    for (int k = 0; k < 20 && (m_cnt != 0 || m_rv); k++) tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    errs = 0;
    checks = 0;
    m_cnt = 0;
    m_rv = 0;
    reset_i = 1;
    flush_i = 0;
    res_ready_i = 0;
    set_cmd(0, 8'd0, 8'd0, OP_ADD);

    vecs[0]  = '{8'hF0, 8'h3C, OP_ADD,  8'h2C};
    vecs[1]  = '{8'hF0, 8'h3C, OP_SUB,  8'hB4};
    vecs[2]  = '{8'hF0, 8'h3C, OP_AND,  8'h30};
    vecs[3]  = '{8'hF0, 8'h3C, OP_OR,   8'hFC};
    vecs[4]  = '{8'hF0, 8'h3C, OP_XOR,  8'hCC};
    vecs[5]  = '{8'hF0, 8'h3C, OP_SLL,  8'h00};
    vecs[6]  = '{8'hF0, 8'h3C, OP_SRL,  8'h0F};
    vecs[7]  = '{8'hF0, 8'h3C, OP_SLTU, 8'h00};
    vecs[8]  = '{8'h12, 8'h35, OP_SUB,  8'hDD};
    vecs[9]  = '{8'h12, 8'h35, OP_SLTU, 8'h01};
    vecs[10] = '{8'h81, 8'h01, OP_SLL,  8'h02};
    vecs[11] = '{8'hFF, 8'h01, OP_ADD,  8'h00};

    #1;
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_res", res_o, 0);
    chk("rst_res_op", res_op_o, OP_ADD);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_i = 0;

    // single command: 5 + 3
    res_ready_i = 1;
    set_cmd(1, 8'd5, 8'd3, OP_ADD);
    tick();
    chk("single_cnt1", count_o, 1);
    chk("single_rv0", res_valid_o, 0);
    set_cmd(0, 8'd0, 8'd0, OP_ADD);
    tick();
    chk("single_rv1", res_valid_o, 1);
    chk("single_res", res_o, 8);
    chk("single_op", res_op_o, OP_ADD);
    chk("single_cnt0", count_o, 0);
    drain();

    // vector table streamed back to back
    for (int i = 0; i < 12; i++) begin
      set_cmd(1, vecs[i].a, vecs[i].b, vecs[i].op);
      cur_exp.res = vecs[i].exp;
      tick();
    end
    drain();

    // fill with result side stalled; sixth command refused
    res_ready_i = 0;
    for (int i = 0; i < 6; i++) begin
      set_cmd(1, 8'(i * 17 + 3), 8'(i + 1), operand_t'(i % 8));
      tick();
    end
    chk("full_cnt", count_o, 4);
    chk("full_ready", cmd_ready_o, 0);
    chk("full_rv", res_valid_o, 1);
    // full cycle with both sides active, then push+pop together
    res_ready_i = 1;
    set_cmd(1, 8'd200, 8'd100, OP_SUB);
    tick();
    chk("full_pop_cnt", count_o, 3);
    set_cmd(1, 8'd7, 8'd9, OP_XOR);
    tick();
    chk("pushpop_cnt", count_o, 3);
    drain();

    // flush with 3 queued plus a held result
    res_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1, 8'(i + 40), 8'd2, OP_SLL);
      tick();
    end
    chk("preflush_cnt", count_o, 3);
    chk("preflush_rv", res_valid_o, 1);
    flush_i = 1;
    set_cmd(1, 8'd99, 8'd1, OP_ADD);
    tick();
    flush_i = 0;
    chk("flush_cnt", count_o, 0);
    chk("flush_rv", res_valid_o, 0);
    res_ready_i = 1;
    set_cmd(1, 8'd10, 8'd4, OP_SUB);
    tick();
    set_cmd(0, 8'd0, 8'd0, OP_ADD);
    tick();
    chk("postflush_res", res_o, 6);
    drain();

    // random stream
    for (int n = 0; n < 400; n++) begin
      set_cmd(($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom),
              operand_t'($urandom_range(0, 7)));
      res_ready_i = ($urandom_range(0, 9) < 7);
      flush_i     = ($urandom_range(0, 99) < 2);
      tick();
    end
    drain();

    // asynchronous reset between edges
    res_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1, 8'(i + 1), 8'd1, OP_ADD);
      tick();
    end
    cmd_valid_i = 0;
    #2;
    reset_i = 1;
    #1;
    chk("arst_rv", res_valid_o, 0);
    chk("arst_cnt", count_o, 0);
    chk("arst_res", res_o, 0);
    m_cnt = 0;
    m_rv = 0;
    sb.delete();
    @(posedge clk);
    #1;
    reset_i = 0;
    res_ready_i = 1;
    set_cmd(1, 8'd255, 8'd1, OP_ADD);
    tick();
    set_cmd(0, 8'd0, 8'd0, OP_ADD);
    tick();
    chk("wrap_rv", res_valid_o, 1);
    chk("wrap_res", res_o, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
